spi_adc_master_param: RTL and testbench

//  Parametrised SPI master for the ADC configuration/readback path; successor to the fixed 19-bit single-slave engine.

---
 rtl/spi_adc_master_param_if.sv | 30 +++
 rtl/spi_adc_master_param.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_adc_master_param.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_master_param_if.sv
// Command/response bus of the ADC SPI master: one command per valid/ready
// handshake, one response pulse per frame. Requester uses "master", engine uses "slave".
interface spi_adc_master_param_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int CS_W   = 1
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [CS_W-1:0]   cmd_cs;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cpol;
  logic              cpha;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_cs, cmd_addr, cmd_wdata, cpol, cpha,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_cs, cmd_addr, cmd_wdata, cpol, cpha,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/spi_adc_master_param.sv
// Parametrised SPI master (all CPOL/CPHA modes, NUM_CS selects) for ADC register access.
// Optional macro SPI_LOOPBACK_EN: capture the driven mosi instead of the miso pin.
module spi_adc_master_param #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 2,
  parameter int CS_IDLE = 2
) (
  input  logic                user_clk,
  input  logic                user_rst,
  spi_adc_master_param_if.slave bus,
  output logic                sclk,
  output logic [NUM_CS-1:0]   ss_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HALF_W  = $clog2(2 * FRAME_W);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                err_q, err_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                sclk_q, sclk_d;
  logic [NUM_CS-1:0]   ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;

  logic               accept;
  logic               div_done;
  logic               edge_now;
  logic               edge_lead;
  logic               sample_now;
  logic               rx_bit;
  logic [FRAME_W-1:0] frame_in;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] cs);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

`ifdef SPI_LOOPBACK_EN
  logic miso_unused;
  assign miso_unused = miso;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = miso;
`endif

  assign accept    = bus.cmd_valid && cmd_ready_q;
  assign div_done  = (cnt_q == DIV_LAST);
  assign frame_in  = {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
  // Edges happen at the start of each half-period; the next half index is even (leading) when half_q is odd.
  assign edge_now  = div_done && ((state_q == S_SETUP) ||
                                  (state_q == S_SHIFT && half_q != HALF_LAST));
  assign edge_lead = (state_q == S_SETUP) || half_q[0];
  assign sample_now = edge_lead ^ cpha_q;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      sclk_q      <= 1'b0;
      ss_n_q      <= '1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      err_q       <= err_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    half_d  = half_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_SETUP;
      end
      S_SETUP: if (div_done) begin
        state_d = S_SHIFT;
        cnt_d   = '0;
        half_d  = '0;
      end
      S_SHIFT: if (div_done) begin
        cnt_d = '0;
        if (half_q == HALF_LAST) state_d = S_HOLD;
        else                     half_d  = half_q + 1'b1;
      end
      S_HOLD: if (div_done) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: if (cnt_q == GAP_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    err_d       = err_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = bus.cpol;
        if (accept) begin
          cpol_d      = bus.cpol;
          cpha_d      = bus.cpha;
          err_d       = (int'(bus.cmd_cs) >= NUM_CS);
          rx_d        = '0;
          cmd_ready_d = 1'b0;
          ss_n_d      = cs_decode(bus.cmd_cs);
          // With cpha=0 the MSB is presented before the first edge, so drive edges start at bit FRAME_W-2.
          if (bus.cpha) begin
            tx_d = frame_in;
          end else begin
            tx_d   = frame_in << 1;
            mosi_d = bus.cmd_rw;
          end
        end
      end
      S_SETUP, S_SHIFT: begin
        if (state_q == S_SETUP) sclk_d = cpol_q;
        if (edge_now) begin
          sclk_d = ~sclk_q;
          if (sample_now) begin
            rx_d = {rx_q[DATA_W-2:0], rx_bit};
          end else begin
            mosi_d = tx_q[FRAME_W-1];
            tx_d   = tx_q << 1;
          end
        end
      end
      S_HOLD: begin
        sclk_d = cpol_q;
        if (div_done) begin
          ss_n_d      = '1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = err_q ? '0 : rx_q;
          rsp_err_d   = err_q;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) cmd_ready_d = 1'b1;
      end
      default: begin
        ss_n_d      = '1;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = ~cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign sclk          = sclk_q;
  assign ss_n          = ss_n_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_adc_master_param.sv
// Directed bench for spi_adc_master_param: vector table of frames against an SPI slave model,
// plus hand sequences for reset abort, back-to-back commands and an out-of-range select.
module tb_spi_adc_master_param;

  logic       user_clk = 1'b0;
  logic       user_rst = 1'b0;
  logic       sclk, mosi, sclk2, mosi2;
  logic [1:0] ss_n;
  logic [2:0] ss_n2;
  logic       miso  = 1'b0;
  logic       miso2 = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 user_clk = ~user_clk;

  spi_adc_master_param_if #(.ADDR_W(15), .DATA_W(8), .CS_W(1)) bus ();
  spi_adc_master_param_if #(.ADDR_W(15), .DATA_W(8), .CS_W(2)) bus2 ();

  spi_adc_master_param #(.ADDR_W(15), .DATA_W(8), .CLK_DIV(4), .NUM_CS(2), .CS_IDLE(2)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .bus(bus.slave),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  spi_adc_master_param #(.ADDR_W(15), .DATA_W(8), .CLK_DIV(4), .NUM_CS(3), .CS_IDLE(2)) dut2 (
    .user_clk(user_clk), .user_rst(user_rst), .bus(bus2.slave),
    .sclk(sclk2), .ss_n(ss_n2), .mosi(mosi2), .miso(miso2)
  );

  typedef struct {
    logic        rw;
    logic        cs;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        cpol;
    logic        cpha;
    logic [7:0]  sresp;
    logic [1:0]  exp_ss;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[5];

  // slave model / monitor state
  logic        s_cpol, s_cpha;
  logic [23:0] s_resp;
  logic [23:0] slv_rx;
  logic [1:0]  ss_seen;
  logic        sclk_prev, sel_prev;
  logic [7:0]  last_rd;
  logic        last_err;
  int          bitk, rsp_cnt, rsp_ss_bad, rise_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    rsp_cnt = 0; rsp_ss_bad = 0; rise_cnt = 0; bitk = 0;
    slv_rx = '0; ss_seen = 2'b11; sel_prev = 1'b0; sclk_prev = sclk;
  endtask

  task automatic mon_step();
    logic sel;
    sel = (ss_n != 2'b11);
    if (bus.rsp_valid) begin
      rsp_cnt++;
      last_rd  = bus.rsp_rdata;
      last_err = bus.rsp_err;
      if (sel) rsp_ss_bad++;
    end
    if (sel) ss_seen = ss_n;
    if (!bus.cmd_ready && sclk && !sclk_prev) rise_cnt++;
    if (sel && !sel_prev) begin
      bitk = 0;
      if (!s_cpha) miso = s_resp[23];
    end else if (sel && sclk != sclk_prev) begin
      if (sclk_prev == s_cpol) begin
        if (!s_cpha) slv_rx = {slv_rx[22:0], mosi};
        else begin
          miso = (bitk < 24) ? s_resp[23-bitk] : 1'b0;
          bitk++;
        end
      end else begin
        if (!s_cpha) begin
          bitk++;
          miso = (bitk < 24) ? s_resp[23-bitk] : 1'b0;
        end else slv_rx = {slv_rx[22:0], mosi};
      end
    end
    sclk_prev = sclk;
    sel_prev  = sel;
  endtask

  // Holds cmd_valid until the engine is idle, returns #1 after the accepting edge.
  task automatic accept_main(output bit ok);
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge user_clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge user_clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    bit ok;
    int lo;
    logic [7:0] exp_rd;
    bus.cmd_rw = v.rw; bus.cmd_cs = v.cs; bus.cmd_addr = v.addr; bus.cmd_wdata = v.wdata;
    bus.cpol = v.cpol; bus.cpha = v.cpha;
    s_cpol = v.cpol; s_cpha = v.cpha; s_resp = {16'h0000, v.sresp};
    repeat (2) @(negedge user_clk);
    accept_main(ok);
    chk($sformatf("v%0d_accept", idx), 32'(ok), 32'd1);
    bus.cmd_valid = 1'b0;
    bus.cpol = ~v.cpol;
    bus.cpha = ~v.cpha;
    mon_clear();
    lo = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge user_clk);
      mon_step();
      if (bus.cmd_ready) break;
      lo++;
    end
`ifdef SPI_LOOPBACK_EN
    exp_rd = v.wdata;
`else
    exp_rd = v.exp_rd;
`endif
    chk($sformatf("v%0d_ready_low", idx), 32'(lo), 32'd202);
    chk($sformatf("v%0d_rsp_count", idx), 32'(rsp_cnt), 32'd1);
    chk($sformatf("v%0d_rsp_rdata", idx), 32'(last_rd), 32'(exp_rd));
    chk($sformatf("v%0d_rsp_err", idx), 32'(last_err), 32'd0);
    chk($sformatf("v%0d_rsp_ss_high", idx), 32'(rsp_ss_bad), 32'd0);
    chk($sformatf("v%0d_ss_n", idx), 32'(ss_seen), 32'(v.exp_ss));
    chk($sformatf("v%0d_sclk_rises", idx), 32'(rise_cnt), 32'd24);
    chk($sformatf("v%0d_mosi_frame", idx), 32'(slv_rx), 32'({v.rw, v.addr, v.wdata}));
  endtask

  initial begin
    bit ok;
    int gap, rdy_hi, ss_low, rises, rcnt;
    logic seen_low, done, s2p, rerr;
    logic [7:0] rrd;

    vecs[0] = '{rw:1'b0, cs:1'b0, addr:15'h0190, wdata:8'hA5, cpol:1'b0, cpha:1'b0, sresp:8'h96, exp_ss:2'b10, exp_rd:8'h96};
    vecs[1] = '{rw:1'b1, cs:1'b1, addr:15'h1234, wdata:8'h00, cpol:1'b1, cpha:1'b1, sresp:8'h3C, exp_ss:2'b01, exp_rd:8'h3C};
    vecs[2] = '{rw:1'b1, cs:1'b0, addr:15'h7FFF, wdata:8'h5A, cpol:1'b0, cpha:1'b1, sresp:8'hC3, exp_ss:2'b10, exp_rd:8'hC3};
    vecs[3] = '{rw:1'b1, cs:1'b1, addr:15'h0001, wdata:8'h5A, cpol:1'b1, cpha:1'b0, sresp:8'h00, exp_ss:2'b01, exp_rd:8'h00};
    vecs[4] = '{rw:1'b0, cs:1'b0, addr:15'h4AB5, wdata:8'hFF, cpol:1'b0, cpha:1'b0, sresp:8'h81, exp_ss:2'b10, exp_rd:8'h81};

    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_cs = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_rw = 1'b0; bus2.cmd_cs = '0; bus2.cmd_addr = '0;
    bus2.cmd_wdata = '0; bus2.cpol = 1'b0; bus2.cpha = 1'b0;
    s_cpol = 1'b0; s_cpha = 1'b0; s_resp = '0;
    last_rd = '0; last_err = 1'b0;
    mon_clear();

    #1 user_rst = 1'b1;
    repeat (3) @(negedge user_clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'd3);
    chk("rst_mosi", 32'(mosi), 32'd0);
    user_rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Reset in the middle of a mode-0 frame
    bus.cmd_rw = 1'b1; bus.cmd_cs = 1'b0; bus.cmd_addr = 15'h0055; bus.cmd_wdata = 8'h11;
    bus.cpol = 1'b0; bus.cpha = 1'b0;
    repeat (2) @(negedge user_clk);
    accept_main(ok);
    bus.cmd_valid = 1'b0;
    repeat (60) @(negedge user_clk);
    chk("abort_in_frame", 32'(ss_n), 32'd2);
    user_rst = 1'b1;
    #1;
    chk("abort_ss_n", 32'(ss_n), 32'd3);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge user_clk);
    user_rst = 1'b0;
    mon_clear();
    repeat (250) begin
      @(negedge user_clk);
      mon_step();
    end
    chk("abort_no_rsp", 32'(rsp_cnt), 32'd0);

    // Back-to-back: valid held across two commands
    bus.cmd_rw = 1'b0; bus.cmd_cs = 1'b0; bus.cmd_addr = 15'h0AAA; bus.cmd_wdata = 8'h33;
    accept_main(ok);
    bus.cmd_cs = 1'b1; bus.cmd_addr = 15'h0BBB; bus.cmd_wdata = 8'h44;
    seen_low = 1'b0; done = 1'b0; gap = 0; rdy_hi = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge user_clk);
      if (ss_n != 2'b11) begin
        if (gap > 0) begin done = 1'b1; break; end
        seen_low = 1'b1;
      end else if (seen_low) begin
        gap++;
        if (bus.cmd_ready) rdy_hi++;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_second_frame", 32'(done), 32'd1);
    chk("b2b_second_ss_n", 32'(ss_n), 32'd1);
    chk("b2b_ready_cycles", 32'(rdy_hi), 32'd1);
    chk("b2b_gap_min", 32'(gap >= 3), 32'd1);
    for (int c = 0; c < 1000; c++) begin
      @(negedge user_clk);
      if (bus.cmd_ready) break;
    end
    chk("b2b_idle", 32'(bus.cmd_ready), 32'd1);

    // Out-of-range select on the 3-select instance
    bus2.cmd_rw = 1'b1; bus2.cmd_cs = 2'd3; bus2.cmd_addr = 15'h0123; bus2.cmd_wdata = 8'h5A;
    bus2.cmd_valid = 1'b1;
    @(posedge user_clk);
    #1;
    bus2.cmd_valid = 1'b0;
    ss_low = 0; rises = 0; rcnt = 0; rrd = 8'hEE; rerr = 1'b0; s2p = sclk2;
    for (int c = 0; c < 400; c++) begin
      @(negedge user_clk);
      if (ss_n2 != 3'b111) ss_low++;
      if (!bus2.cmd_ready && sclk2 && !s2p) rises++;
      s2p = sclk2;
      if (bus2.rsp_valid) begin rcnt++; rrd = bus2.rsp_rdata; rerr = bus2.rsp_err; end
      if (bus2.cmd_ready) break;
    end
    chk("bad_cs_ss_n", 32'(ss_low), 32'd0);
    chk("bad_cs_sclk_rises", 32'(rises), 32'd24);
    chk("bad_cs_rsp_count", 32'(rcnt), 32'd1);
    chk("bad_cs_rsp_err", 32'(rerr), 32'd1);
    chk("bad_cs_rsp_rdata", 32'(rrd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
